// File: rtl/e15_core_param.sv
// rtl/e15_core_param.sv - parametrised E15 core with program load, run/halt FSM and debug read
// Optional carry flag and jc/jnc are built when E15_CARRY_EN is defined.
module e15_core_param #(
  parameter int DATA_W = 4,
  parameter int RA_W   = 2,
  parameter int PC_W   = 4,
  localparam int IW    = 4 + 2*RA_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              progWe,
  input  logic [PC_W-1:0]   progAddr,
  input  logic [IW-1:0]     progData,
  output logic              running,
  output logic              halted,
  output logic [PC_W-1:0]   pcOut,
  output logic              zFlagOut,
  output logic              cFlagOut,
  input  logic [RA_W-1:0]   dbgSel,
  output logic [DATA_W-1:0] dbgVal
);

  localparam logic [3:0] OP_JMP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_JZ   = 4'b0010;
  localparam logic [3:0] OP_JNZ  = 4'b0011;
`ifdef E15_CARRY_EN
  localparam logic [3:0] OP_JC   = 4'b0100;
  localparam logic [3:0] OP_JNC  = 4'b0101;
`endif
  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_MOVI = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_ADDI = 4'b1011;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_SUBI = 4'b1101;
  localparam logic [3:0] OP_CMP  = 4'b1110;
  localparam logic [3:0] OP_CMPI = 4'b1111;

  typedef enum logic [1:0] {sIdle, sRun, sHalt} stateT;

  stateT             state, stateNext;
  logic [PC_W-1:0]   pc, pcNext, pcInc, pcJmp, offset;
  logic              zFlag, cFlag;
  logic [DATA_W-1:0] regs [2**RA_W];
  logic [IW-1:0]     rom  [2**PC_W];

  logic [IW-1:0]     instr;
  logic [3:0]        opcode;
  logic [RA_W-1:0]   src, dst;
  logic [DATA_W-1:0] imm, op1, op2, opB, aluRes, regWData;
  logic              isSub, regWe, flagWe, clrFlags;

  assign instr  = rom[pc];
  assign opcode = instr[IW-1 -: 4];
  assign src    = instr[DATA_W+2*RA_W-1 -: RA_W];
  assign dst    = instr[DATA_W+RA_W-1 -: RA_W];
  assign imm    = instr[DATA_W-1:0];

  // Immediate forms (addi/subi/cmpi) all have opcode bit 0 set.
  assign op1   = opcode[0] ? imm : regs[src];
  assign op2   = regs[dst];
  assign isSub = (opcode[3:2] == 2'b11);
  assign opB   = isSub ? ~op1 : op1;

`ifdef E15_CARRY_EN
  logic aluCarry;
  assign {aluCarry, aluRes} = {1'b0, op2} + {1'b0, opB} + (DATA_W+1)'(isSub);
`else
  assign aluRes = op2 + opB + DATA_W'(isSub);
`endif

  // Short immediates are signed so backward branches work on narrow data.
  generate
    if (DATA_W < PC_W) begin : gSext
      assign offset = {{(PC_W-DATA_W){imm[DATA_W-1]}}, imm};
    end else begin : gTrunc
      assign offset = imm[PC_W-1:0];
    end
  endgenerate

  assign pcInc = pc + PC_W'(1);
  assign pcJmp = pc + offset;

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    regWe     = 1'b0;
    regWData  = aluRes;
    flagWe    = 1'b0;
    clrFlags  = 1'b0;
    unique case (state)
      sIdle, sHalt: begin
        if (start) begin
          stateNext = sRun;
          pcNext    = '0;
          clrFlags  = 1'b1;
        end
      end
      sRun: begin
        pcNext = pcInc;
        case (opcode)
          OP_JMP:  pcNext = pcJmp;
          OP_HALT: begin
            pcNext    = pc;
            stateNext = sHalt;
          end
          OP_JZ:   if (zFlag)  pcNext = pcJmp;
          OP_JNZ:  if (!zFlag) pcNext = pcJmp;
`ifdef E15_CARRY_EN
          OP_JC:   if (cFlag)  pcNext = pcJmp;
          OP_JNC:  if (!cFlag) pcNext = pcJmp;
`endif
          OP_MOV: begin
            regWe    = 1'b1;
            regWData = regs[src];
          end
          OP_MOVI: begin
            regWe    = 1'b1;
            regWData = imm;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            regWe  = 1'b1;
            flagWe = 1'b1;
          end
          OP_CMP, OP_CMPI: flagWe = 1'b1;
          default: ;
        endcase
      end
      default: stateNext = sIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= sIdle;
      pc    <= '0;
      zFlag <= 1'b0;
      for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (clrFlags)    zFlag <= 1'b0;
      else if (flagWe) zFlag <= (aluRes == '0);
      if (regWe) regs[dst] <= regWData;
    end
  end

`ifdef E15_CARRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cFlag <= 1'b0;
    else if (clrFlags)  cFlag <= 1'b0;
    else if (flagWe)    cFlag <= aluCarry;
  end
`else
  assign cFlag = 1'b0;
`endif

  // Program memory is deliberately left out of reset so a loaded image survives it.
  always_ff @(posedge clk) begin
    if (progWe && state != sRun) rom[progAddr] <= progData;
  end

  assign running  = (state == sRun);
  assign halted   = (state == sHalt);
  assign pcOut    = pc;
  assign zFlagOut = zFlag;
  assign cFlagOut = cFlag;
  assign dbgVal   = regs[dbgSel];

endmodule

// File: tb/tb_e15_core_param.sv
// tb/tb_e15_core_param.sv - table-driven bench for e15_core_param (default and 8/3/6 builds)
module tb_e15_core_param;

`ifdef E15_CARRY_EN
  localparam logic CARRY = 1'b1;
`else
  localparam logic CARRY = 1'b0;
`endif

  localparam logic [3:0] JMP = 4'b0000, HLT = 4'b0001, JZ = 4'b0010, JNZ = 4'b0011;
  localparam logic [3:0] JC = 4'b0100, NOP = 4'b0110, MOV = 4'b1000, MOVI = 4'b1001;
  localparam logic [3:0] ADD = 4'b1010, ADDI = 4'b1011, SUBI = 4'b1101, CMPI = 4'b1111;

  logic clk, rst_n;

  logic        start, progWe, running, halted, zFlagOut, cFlagOut;
  logic [3:0]  progAddr, pcOut, dbgVal;
  logic [11:0] progData;
  logic [1:0]  dbgSel;

  logic        start8, progWe8, running8, halted8, zFlagOut8, cFlagOut8;
  logic [5:0]  progAddr8, pcOut8;
  logic [17:0] progData8;
  logic [2:0]  dbgSel8;
  logic [7:0]  dbgVal8;

  e15_core_param dut (
    .clk(clk), .rst_n(rst_n), .start(start), .progWe(progWe), .progAddr(progAddr),
    .progData(progData), .running(running), .halted(halted), .pcOut(pcOut),
    .zFlagOut(zFlagOut), .cFlagOut(cFlagOut), .dbgSel(dbgSel), .dbgVal(dbgVal)
  );

  e15_core_param #(.DATA_W(8), .RA_W(3), .PC_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .progWe(progWe8), .progAddr(progAddr8),
    .progData(progData8), .running(running8), .halted(halted8), .pcOut(pcOut8),
    .zFlagOut(zFlagOut8), .cFlagOut(cFlagOut8), .dbgSel(dbgSel8), .dbgVal(dbgVal8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][11:0] prog;
    logic [2:0]       len;
    logic [1:0]       sel;
    logic [3:0]       expReg;
    logic             expZ;
    logic             expC;
    logic [3:0]       expPc;
    logic [4:0]       expEdges;
  } vecT;

  vecT vec [8];
  vecT sbq [$];
  int  tests = 0;
  int  failed = 0;

  function automatic logic [11:0] enc(logic [3:0] op, logic [1:0] s, logic [1:0] d, logic [3:0] im);
    return {op, s, d, im};
  endfunction

  function automatic logic [17:0] enc8(logic [3:0] op, logic [2:0] s, logic [2:0] d, logic [7:0] im);
    return {op, s, d, im};
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vecT mk(int len, logic [1:0] sel, logic [3:0] r, logic z, logic c,
                             logic [3:0] pc, int edges);
    vecT v;
    v          = '0;
    v.len      = 3'(len);
    v.sel      = sel;
    v.expReg   = r;
    v.expZ     = z;
    v.expC     = c;
    v.expPc    = pc;
    v.expEdges = 5'(edges);
    return v;
  endfunction

  // Load a program (start rides on the last write), run to HALT, then score.
  task automatic runVec(input int i);
    int  cnt;
    vecT e;
    for (int w = 0; w < int'(vec[i].len); w++) begin
      progWe   = 1'b1;
      progAddr = 4'(w);
      progData = vec[i].prog[w];
      if (w == int'(vec[i].len) - 1) begin
        start = 1'b1;
        sbq.push_back(vec[i]);
      end
      @(negedge clk);
    end
    progWe = 1'b0;
    start  = 1'b0;
    cnt    = 1;
    while (!halted && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    e      = sbq.pop_front();
    dbgSel = e.sel;
    #1;
    check($sformatf("v%0d_edges", i), cnt, e.expEdges);
    check($sformatf("v%0d_reg", i), dbgVal, e.expReg);
    check($sformatf("v%0d_z", i), zFlagOut, e.expZ);
    check($sformatf("v%0d_c", i), cFlagOut, e.expC);
    check($sformatf("v%0d_pc", i), pcOut, e.expPc);
    check($sformatf("v%0d_halted", i), halted, 1);
    check($sformatf("v%0d_running", i), running, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; progWe = 1'b0; progAddr = '0; progData = '0; dbgSel = '0;
    start8 = 1'b0; progWe8 = 1'b0; progAddr8 = '0; progData8 = '0; dbgSel8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pcOut, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_z", zFlagOut, 0);
    check("rst_c", cFlagOut, 0);
    check("rst_pc8", pcOut8, 0);
    for (int r = 0; r < 4; r++) begin
      dbgSel = 2'(r);
      #1 check($sformatf("rst_r%0d", r), dbgVal, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    vec[0] = mk(2, 1, 5, 0, 0, 1, 3);
    vec[0].prog[0] = enc(MOVI, 0, 1, 5);
    vec[0].prog[1] = enc(HLT, 0, 0, 0);
    vec[1] = mk(3, 0, 0, 1, CARRY, 2, 4);
    vec[1].prog[0] = enc(MOVI, 0, 0, 15);
    vec[1].prog[1] = enc(ADDI, 0, 0, 1);
    vec[1].prog[2] = enc(HLT, 0, 0, 0);
    vec[2] = mk(3, 2, 3, 1, CARRY, 2, 4);
    vec[2].prog[0] = enc(MOVI, 0, 2, 3);
    vec[2].prog[1] = enc(CMPI, 0, 2, 3);
    vec[2].prog[2] = enc(HLT, 0, 0, 0);
    vec[3] = mk(4, 2, 15, 0, 0, 3, 5);
    vec[3].prog[0] = enc(MOVI, 0, 2, 3);
    vec[3].prog[1] = enc(CMPI, 0, 2, 3);
    vec[3].prog[2] = enc(SUBI, 0, 2, 4);
    vec[3].prog[3] = enc(HLT, 0, 0, 0);
    vec[4] = mk(4, 0, 0, 1, CARRY, 3, 9);
    vec[4].prog[0] = enc(MOVI, 0, 0, 3);
    vec[4].prog[1] = enc(SUBI, 0, 0, 1);
    vec[4].prog[2] = enc(JNZ, 0, 0, 4'hF);
    vec[4].prog[3] = enc(HLT, 0, 0, 0);
    vec[5] = mk(4, 3, 0, 1, CARRY, 3, 5);
    vec[5].prog[0] = enc(MOVI, 0, 1, 7);
    vec[5].prog[1] = enc(MOVI, 0, 3, 9);
    vec[5].prog[2] = enc(ADD, 1, 3, 0);
    vec[5].prog[3] = enc(HLT, 0, 0, 0);
`ifdef E15_CARRY_EN
    vec[6] = mk(5, 0, 0, 1, 1, 4, 5);
`else
    vec[6] = mk(5, 0, 9, 1, 0, 4, 6);
`endif
    vec[6].prog[0] = enc(MOVI, 0, 0, 15);
    vec[6].prog[1] = enc(ADDI, 0, 0, 1);
    vec[6].prog[2] = enc(JC, 0, 0, 2);
    vec[6].prog[3] = enc(MOVI, 0, 0, 9);
    vec[6].prog[4] = enc(HLT, 0, 0, 0);
    vec[7] = mk(5, 1, 6, 0, 0, 4, 6);
    vec[7].prog[0] = enc(MOVI, 0, 2, 6);
    vec[7].prog[1] = enc(MOV, 2, 1, 0);
    vec[7].prog[2] = enc(NOP, 0, 0, 0);
    vec[7].prog[3] = enc(JZ, 0, 0, 5);
    vec[7].prog[4] = enc(HLT, 0, 0, 0);

    for (int i = 0; i < 8; i++) runVec(i);

    // Load blocked in RUN, then asynchronous reset mid-program and restart.
    progWe = 1'b1; progAddr = 4'd0; progData = enc(MOVI, 0, 0, 1);
    @(negedge clk);
    progAddr = 4'd1; progData = enc(JMP, 0, 0, 0); start = 1'b1;
    @(negedge clk);
    progWe = 1'b0; start = 1'b0;
    check("restart_pc0", pcOut, 0);
    check("restart_running", running, 1);
    progWe = 1'b1; progAddr = 4'd1; progData = enc(HLT, 0, 0, 0);
    @(negedge clk);
    progWe = 1'b0;
    repeat (4) @(negedge clk);
    check("blocked_running", running, 1);
    check("blocked_halted", halted, 0);
    check("blocked_pc", pcOut, 1);
    dbgSel = 2'd0;
    #1 check("blocked_r0", dbgVal, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_running", running, 0);
    check("midrst_pc", pcOut, 0);
    check("midrst_r0", dbgVal, 0);
    dbgSel = 2'd1;
    #1 check("midrst_r1", dbgVal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rerun_pc0", pcOut, 0);
    check("rerun_running", running, 1);
    @(negedge clk);
    dbgSel = 2'd0;
    #1;
    check("rerun_pc1", pcOut, 1);
    check("rerun_r0", dbgVal, 1);

    // Wide build: 8-bit wrap with carry, and PC wrap from 63 back to 0.
    progWe8 = 1'b1;
    progAddr8 = 6'd0;  progData8 = enc8(MOVI, 0, 7, 8'd200); @(negedge clk);
    progAddr8 = 6'd1;  progData8 = enc8(ADDI, 0, 7, 8'd100); @(negedge clk);
    progAddr8 = 6'd2;  progData8 = enc8(JMP, 0, 0, 8'd61);   @(negedge clk);
    progAddr8 = 6'd63; progData8 = enc8(NOP, 0, 0, 8'd0);    start8 = 1'b1;
    @(negedge clk);
    progWe8 = 1'b0; start8 = 1'b0;
    check("w_pc0", pcOut8, 0);
    repeat (2) @(negedge clk);
    dbgSel8 = 3'd7;
    #1;
    check("w_r7", dbgVal8, 44);
    check("w_c", cFlagOut8, CARRY);
    check("w_z", zFlagOut8, 0);
    check("w_pc2", pcOut8, 2);
    @(negedge clk);
    check("w_pc63", pcOut8, 63);
    @(negedge clk);
    check("w_wrap", pcOut8, 0);
    check("w_running", running8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
